// File: rtl/pe_array_scheduler_if.sv
// Handshake and strobe bundle between a job controller and the PE array scheduler.
// The master side drives job requests. The slave side is the scheduler, which drives the array strobes.
interface pe_array_scheduler_if;
    logic       start;
    logic [4:0] num_tiles;
    logic       pause;
    logic       abort;
    logic       out_ready;
    logic       buf_clr;
    logic       buf_read_en;
    logic       pe_clear;
    logic       pe_valid;
    logic [2:0] step_idx;
    logic [3:0] tile_idx;
    logic       out_valid;
    logic       busy;
    logic       done;

    modport master (
        output start, num_tiles, pause, abort, out_ready,
        input  buf_clr, buf_read_en, pe_clear, pe_valid, step_idx, tile_idx,
               out_valid, busy, done
    );

    modport slave (
        input  start, num_tiles, pause, abort, out_ready,
        output buf_clr, buf_read_en, pe_clear, pe_valid, step_idx, tile_idx,
               out_valid, busy, done
    );
endinterface

// File: rtl/pe_array_scheduler.sv
// Sequences weight-buffer reads and PE MAC enables over the tiles of a job.
// The job is one pass of VEC_LEN columns per tile, with a drain gap and a result handshake.
module pe_array_scheduler #(
    parameter int PIPE_LAT = 1,
    parameter int VEC_LEN  = 8
) (
    input logic                 clk,
    input logic                 rst,
    pe_array_scheduler_if.slave bus
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CLEAR  = 3'd1;
    localparam logic [2:0] S_RUN    = 3'd2;
    localparam logic [2:0] S_DRAIN  = 3'd3;
    localparam logic [2:0] S_OUTPUT = 3'd4;

    localparam logic [2:0] STEP_LAST  = 3'(VEC_LEN - 1);
    localparam logic [2:0] DRAIN_INIT = 3'(PIPE_LAT - 1);

    logic [2:0] state_q, state_d;
    logic [2:0] step_q, step_d;
    logic [3:0] tile_q, tile_d;
    logic [4:0] ntiles_q, ntiles_d;
    logic [2:0] drain_q, drain_d;
    logic       done_q, done_d;
    logic       abort_clr_q, abort_clr_d;
    logic       last_tile;

    // The tile counter saturates at 15 so an out-of-range tile count cannot wrap it.
    assign last_tile = ({1'b0, tile_q} == (ntiles_q - 5'd1)) || (tile_q == 4'hF);

    always_comb begin
        state_d     = state_q;
        step_d      = step_q;
        tile_d      = tile_q;
        ntiles_d    = ntiles_q;
        drain_d     = drain_q;
        done_d      = 1'b0;
        abort_clr_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    if (bus.num_tiles != 5'd0) begin
                        ntiles_d = bus.num_tiles;
                        tile_d   = 4'd0;
                        step_d   = 3'd0;
                        state_d  = S_CLEAR;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            S_CLEAR: begin
                state_d = S_RUN;
            end
            S_RUN: begin
                if (!bus.pause) begin
                    if (step_q == STEP_LAST) begin
                        drain_d = DRAIN_INIT;
                        state_d = S_DRAIN;
                    end else begin
                        step_d = step_q + 3'd1;
                    end
                end
            end
            S_DRAIN: begin
                if (drain_q == 3'd0) begin
                    state_d = S_OUTPUT;
                end else begin
                    drain_d = drain_q - 3'd1;
                end
            end
            S_OUTPUT: begin
                if (bus.out_ready) begin
                    step_d = 3'd0;
                    if (last_tile) begin
                        tile_d  = 4'd0;
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        tile_d  = tile_q + 4'd1;
                        state_d = S_CLEAR;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort overrides pause, the handshake and the end-of-job pulse.
        if (state_q != S_IDLE && bus.abort) begin
            state_d     = S_IDLE;
            step_d      = 3'd0;
            tile_d      = 4'd0;
            done_d      = 1'b0;
            abort_clr_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            step_q      <= 3'd0;
            tile_q      <= 4'd0;
            ntiles_q    <= 5'd0;
            drain_q     <= 3'd0;
            done_q      <= 1'b0;
            abort_clr_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            tile_q      <= tile_d;
            ntiles_q    <= ntiles_d;
            drain_q     <= drain_d;
            done_q      <= done_d;
            abort_clr_q <= abort_clr_d;
        end
    end

    assign bus.busy        = (state_q != S_IDLE);
    assign bus.done        = done_q;
    assign bus.out_valid   = (state_q == S_OUTPUT);
    assign bus.buf_clr     = (state_q == S_CLEAR) || abort_clr_q;
    assign bus.pe_clear    = (state_q == S_CLEAR);
    assign bus.buf_read_en = (state_q == S_RUN) && !bus.pause;
    assign bus.pe_valid    = (state_q == S_RUN) && !bus.pause;
    assign bus.step_idx    = step_q;
    assign bus.tile_idx    = tile_q;
endmodule

// File: tb/tb_pe_array_scheduler.sv
// Directed bench for pe_array_scheduler with hand-computed per-cycle output vectors.
module tb_pe_array_scheduler;
    logic clk;
    logic rst;
    pe_array_scheduler_if bus();

    pe_array_scheduler #(.PIPE_LAT(1), .VEC_LEN(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    logic [13:0] vlog [0:63];
    int reads, dones, n_ov, first_ov;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Vector order: busy done out_valid buf_clr buf_read_en pe_clear pe_valid step tile
    function automatic logic [13:0] outs();
        return {bus.busy, bus.done, bus.out_valid, bus.buf_clr, bus.buf_read_en,
                bus.pe_clear, bus.pe_valid, bus.step_idx, bus.tile_idx};
    endfunction

    function automatic logic [13:0] mk(bit b, bit d, bit ov, bit bc, bit re, bit pc, bit pv,
                                       int st, int tl);
        return {b, d, ov, bc, re, pc, pv, 3'(st), 4'(tl)};
    endfunction

    task automatic job(input int n, input int ncyc, input int pz_lo, input int pz_hi,
                       input int or_lo, input int or_hi, input int ab_c);
        logic [13:0] v;
        reads = 0; dones = 0; n_ov = 0; first_ov = 0;
        bus.start     = 1'b1;
        bus.num_tiles = 5'(n);
        for (int c = 1; c <= ncyc; c++) begin
            @(posedge clk); #1;
            bus.start = (c == 4);
            if (c == 2) bus.num_tiles = 5'd7;
            bus.pause     = (c >= pz_lo && c <= pz_hi);
            bus.out_ready = !(c >= or_lo && c <= or_hi);
            bus.abort     = (c == ab_c);
            #1;
            v = outs();
            vlog[c] = v;
            if (bus.buf_read_en) reads++;
            if (bus.done) dones++;
            if (bus.out_valid) begin
                n_ov++;
                if (first_ov == 0) first_ov = c;
            end
        end
        bus.start     = 1'b0;
        bus.pause     = 1'b0;
        bus.abort     = 1'b0;
        bus.out_ready = 1'b1;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst           = 1'b0;
        bus.start     = 1'b0;
        bus.num_tiles = 5'd0;
        bus.pause     = 1'b0;
        bus.abort     = 1'b0;
        bus.out_ready = 1'b1;
        #1;
        chk("reset_async", 32'(outs()), 32'(mk(0,0,0,0,0,0,0,0,0)));
        repeat (2) @(posedge clk);
        #1;
        chk("reset_held", 32'(outs()), 32'(mk(0,0,0,0,0,0,0,0,0)));
        @(negedge clk);
        rst = 1'b1;

        // Single tile, first start right after reset release
        job(1, 14, 0, -1, 0, -1, 0);
        chk("A_clear", 32'(vlog[1]), 32'(mk(1,0,0,1,0,1,0,0,0)));
        for (int k = 0; k < 8; k++)
            chk("A_run", 32'(vlog[2 + k]), 32'(mk(1,0,0,0,1,0,1,k,0)));
        chk("A_drain", 32'(vlog[10]), 32'(mk(1,0,0,0,0,0,0,7,0)));
        chk("A_out",   32'(vlog[11]), 32'(mk(1,0,1,0,0,0,0,7,0)));
        chk("A_done",  32'(vlog[12]), 32'(mk(0,1,0,0,0,0,0,0,0)));
        chk("A_idle",  32'(vlog[13]), 32'(mk(0,0,0,0,0,0,0,0,0)));
        chk("A_reads", 32'(reads), 32'd8);

        // Three tiles; num_tiles changes and a start pulse arrive mid-job
        job(3, 40, 0, -1, 0, -1, 0);
        chk("B_reads", 32'(reads), 32'd24);
        chk("B_dones", 32'(dones), 32'd1);
        chk("B_ov0",   32'(vlog[11]), 32'(mk(1,0,1,0,0,0,0,7,0)));
        chk("B_ov1",   32'(vlog[22]), 32'(mk(1,0,1,0,0,0,0,7,1)));
        chk("B_ov2",   32'(vlog[33]), 32'(mk(1,0,1,0,0,0,0,7,2)));
        chk("B_done",  32'(vlog[34]), 32'(mk(0,1,0,0,0,0,0,0,0)));

        // Pause for 3 cycles at step 4
        job(1, 20, 6, 8, 0, -1, 0);
        chk("C_pause_first", 32'(vlog[6]), 32'(mk(1,0,0,0,0,0,0,4,0)));
        chk("C_pause_last",  32'(vlog[8]), 32'(mk(1,0,0,0,0,0,0,4,0)));
        chk("C_resume",      32'(vlog[9]), 32'(mk(1,0,0,0,1,0,1,4,0)));
        chk("C_reads",       32'(reads), 32'd8);
        chk("C_first_ov",    32'(first_ov), 32'd14);
        chk("C_dones",       32'(dones), 32'd1);

        // Downstream back-pressure for 5 cycles on the first tile
        job(2, 32, 0, -1, 11, 15, 0);
        chk("D_hold_first", 32'(vlog[11]), 32'(mk(1,0,1,0,0,0,0,7,0)));
        chk("D_hold_last",  32'(vlog[15]), 32'(mk(1,0,1,0,0,0,0,7,0)));
        chk("D_handshake",  32'(vlog[16]), 32'(mk(1,0,1,0,0,0,0,7,0)));
        chk("D_clear_t1",   32'(vlog[17]), 32'(mk(1,0,0,1,0,1,0,0,1)));
        chk("D_n_ov",       32'(n_ov), 32'd7);
        chk("D_reads",      32'(reads), 32'd16);
        chk("D_done",       32'(vlog[28]), 32'(mk(0,1,0,0,0,0,0,0,0)));

        // Abort together with pause at step 5 of tile 1
        job(3, 24, 18, 18, 0, -1, 18);
        chk("E_at_abort",  32'(vlog[18]), 32'(mk(1,0,0,0,0,0,0,5,1)));
        chk("E_after",     32'(vlog[19]), 32'(mk(0,0,0,1,0,0,0,0,0)));
        chk("E_settled",   32'(vlog[20]), 32'(mk(0,0,0,0,0,0,0,0,0)));
        chk("E_dones",     32'(dones), 32'd0);
        chk("E_reads",     32'(reads), 32'd13);

        // Zero-tile start produces only a done pulse
        bus.start     = 1'b1;
        bus.num_tiles = 5'd0;
        @(posedge clk); #1;
        bus.start = 1'b0;
        #1;
        chk("Z_done", 32'(outs()), 32'(mk(0,1,0,0,0,0,0,0,0)));
        @(posedge clk); #2;
        chk("Z_idle", 32'(outs()), 32'(mk(0,0,0,0,0,0,0,0,0)));

        // Reset during DRAIN, then a fresh job
        job(1, 10, 0, -1, 0, -1, 0);
        chk("F_drain", 32'(vlog[10]), 32'(mk(1,0,0,0,0,0,0,7,0)));
        rst = 1'b0;
        #1;
        chk("F_rst_async", 32'(outs()), 32'(mk(0,0,0,0,0,0,0,0,0)));
        @(negedge clk);
        rst = 1'b1;
        job(1, 16, 0, -1, 0, -1, 0);
        chk("F_clear",    32'(vlog[1]), 32'(mk(1,0,0,1,0,1,0,0,0)));
        chk("F_reads",    32'(reads), 32'd8);
        chk("F_first_ov", 32'(first_ov), 32'd11);
        chk("F_done",     32'(vlog[12]), 32'(mk(0,1,0,0,0,0,0,0,0)));

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/pe_array_scheduler.md
PE_ARRAY_SCHEDULER -- requirements
Module: pe_array_scheduler

Interface
REQ-001 SHALL have parameter PIPE_LAT, default 1, meaning cycles from last MAC enable to accumulator result valid (legal 1..4).
REQ-002 SHALL have parameter VEC_LEN, default 8, meaning weight-buffer reads per tile pass; it equals the circular-buffer depth.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port start  input  1  request to run a job; sampled only in IDLE.
REQ-006 SHALL have port num_tiles  input  5  tiles per job (1..16); latched on accepted start.
REQ-007 SHALL have port pause  input  1  freezes the MAC sequence while high in RUN.
REQ-008 SHALL have port abort  input  1  synchronous job cancel.
REQ-009 SHALL have port out_ready  input  1  downstream accepts the tile result.
REQ-010 SHALL have port buf_clr  output  1  clears the weight-buffer read pointer to 0.
REQ-011 SHALL have port buf_read_en  output  1  advances the weight-buffer read pointer.
REQ-012 SHALL have port pe_clear  output  1  zeroes the 8 PE accumulators.
REQ-013 SHALL have port pe_valid  output  1  PE MAC enable for the current weight column.
REQ-014 SHALL have port step_idx  output  3  current column index within the pass.
REQ-015 SHALL have port tile_idx  output  4  current tile index.
REQ-016 SHALL have port out_valid  output  1  tile result available.
REQ-017 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-018 SHALL have port done  output  1  one-cycle end-of-job pulse.

Function
REQ-019 SHALL implement the states IDLE, CLEAR, RUN, DRAIN and OUTPUT; all outputs are decoded from the registered state and counters.
REQ-020 IDLE: when start=1 and num_tiles!=0, SHALL latch num_tiles, set tile_idx=0, and go to CLEAR.
REQ-020a IDLE: when start=1 and num_tiles==0, SHALL stay in IDLE and pulse done on the next cycle.
REQ-021 CLEAR, lasting exactly 1 cycle: buf_clr=1, pe_clear=1, step_idx=0; next state RUN.
REQ-022 RUN with pause=0: buf_read_en=1, pe_valid=1; step_idx increments each cycle; at step_idx==VEC_LEN-1 the next state is DRAIN.
REQ-023 RUN with pause=1: buf_read_en=0, pe_valid=0, step_idx held; the sequence resumes at the same step when pause falls.
REQ-024 DRAIN: all strobes are 0 for exactly PIPE_LAT cycles via a down-counter; next state OUTPUT.
REQ-025 OUTPUT: out_valid=1 with tile_idx stable until out_ready=1; the handshake completes in a cycle with out_valid & out_ready.
REQ-025a On handshake, if tile_idx==latched num_tiles-1: go to IDLE and pulse done on the following cycle.
REQ-025b On handshake otherwise: tile_idx increments and the next state is CLEAR.
REQ-026 SHALL produce exactly VEC_LEN buf_read_en pulses per tile and VEC_LEN*num_tiles per job.
REQ-027 Latency, with no pause and out_ready=1: start accepted at cycle 0 -> CLEAR at cycle 1, RUN at cycles 2..9, DRAIN at 10..9+PIPE_LAT, out_valid at 10+PIPE_LAT.
REQ-028 SHALL ignore start while busy=1, and changes to num_tiles after it is latched.
REQ-029 abort=1 in any non-IDLE state: next state IDLE; no done pulse; buf_clr=1 for that one transition cycle.
REQ-029a abort has priority over pause and out_ready.
REQ-030 In RUN, abort and pause both high: abort wins.
REQ-031 pause outside RUN: no effect.
REQ-032 Counters SHALL never wrap: step_idx covers 0..VEC_LEN-1; tile_idx covers 0..num_tiles-1.

Reset
REQ-033 rst low SHALL force, asynchronously, state=IDLE, with all outputs and counters 0 (busy=0, done=0, out_valid=0, buf_read_en=0, pe_valid=0, buf_clr=0, pe_clear=0, step_idx=0, tile_idx=0).
REQ-034 Reset mid-job SHALL discard the job; after rst rises, the block waits in IDLE for a new start.
REQ-035 The first start SHALL be accepted on the first rising edge after rst deasserts.

Verification
REQ-036 num_tiles=1, PIPE_LAT=1, out_ready=1 -> pe_clear at cycle 1; 8 read_en at cycles 2..9; out_valid at 11; done at 12; busy low at 12.
REQ-037 num_tiles=3, out_ready=1 -> 24 read_en pulses total; tile_idx 0,1,2 on each out_valid; exactly one done.
REQ-038 pause high for 3 cycles at step_idx=4 -> read_en/pe_valid low for 3 cycles; step_idx holds at 4; total reads still 8; out_valid delayed 3 cycles.
REQ-039 out_ready low for 5 cycles in OUTPUT -> out_valid and tile_idx stable; no new CLEAR until the handshake.
REQ-040 abort at step_idx=5 of tile 1 -> IDLE next cycle with buf_clr=1 and no done; start with num_tiles=0 -> only a done pulse.
REQ-041 rst low during DRAIN -> all outputs 0 immediately, without waiting for a clock edge; a later start runs a full job normally.
